systolic_result_buffer: RTL and testbench
=========================================

Name: systolic_result_buffer

Overview:
Parametrised result store behind the systolic array. It accepts one 2x2 output tile (c1..c4) per cycle through a valid/ready handshake and writes it into a DIM x DIM matrix of ACC_W-bit words, either overwriting or accumulating (for K-split partial sums). It tracks which tiles have been written, raises frame_done when the matrix is complete, supports a multi-cycle row-sweep clear, and provides a registered random-access read port for drain to the host.

Parameters:
DATA_W, 8, operand width of the array; documentation only, ACC_W is normally 2*DATA_W
ACC_W, 16, stored word width, equal to the c1..c4 width
DIM, 8, matrix dimension; power of two, at least 2
ADDR_W, 3, row/column index width; must equal log2(DIM)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
wr_valid  in  1  tile present
wr_ready  out  1  buffer can accept a tile this cycle
wr_row  in  ADDR_W  tile origin row; bit 0 ignored (treated as 0)
wr_col  in  ADDR_W  tile origin column; bit 0 ignored
wr_acc  in  1  1 = add to stored values, 0 = overwrite
wr_c1  in  ACC_W  value for (r, c)
wr_c2  in  ACC_W  value for (r, c+1)
wr_c3  in  ACC_W  value for (r+1, c)
wr_c4  in  ACC_W  value for (r+1, c+1)
clear  in  1  start clear sweep (single-cycle pulse)
rd_en  in  1  read request
rd_row  in  ADDR_W  read row
rd_col  in  ADDR_W  read column
rd_data  out  ACC_W  read result
rd_valid  out  1  rd_data valid
busy  out  1  clear sweep in progress
frame_done  out  1  all (DIM/2)^2 tiles written since the last clear or reset
dup_err  out  1  sticky: a tile was overwritten (wr_acc=0) after it had already been written

Behaviour:
- States: FILL, CLEAR, DONE.
- Reset: all matrix words are 0 in one cycle, the tile bitmap is 0, state is FILL, and rd_data, rd_valid, busy, frame_done and dup_err are all 0. Reset has priority over every other input, including mid-clear and mid-write.
- wr_ready = (state == FILL) and not clear. It is combinational and does not depend on wr_valid.
- Accept condition: wr_valid and wr_ready at the rising edge. All four words update in that same edge, so write latency is 1 cycle.
- Write modes:
  - wr_acc=0: each word takes its new value.
  - wr_acc=1: each word becomes the stored value plus the new value, modulo 2^ACC_W (wrap, no saturation).
- Tile bitmap: the bit at index (r>>1)*(DIM/2)+(c>>1) is set on accept.
- dup_err: set if an accept with wr_acc=0 hits a tile whose bit is already set. The write still happens.
- Completion: when the accepted tile completes the bitmap, state moves to DONE on that edge and frame_done=1 from the next cycle.
- DONE: wr_ready=0 and frame_done is held until clear.
- clear in FILL or DONE: state moves to CLEAR and the row counter is 0.
  - In each CLEAR cycle, row[counter] is zeroed and the counter increments.
  - After row DIM-1 is zeroed, state returns to FILL.
  - The sweep lasts exactly DIM cycles with busy=1.
  - frame_done, dup_err and the bitmap clear on the edge that enters CLEAR.
- clear during CLEAR restarts the counter at 0.
- clear and wr_valid in the same cycle: clear wins and the tile is not accepted (wr_ready=0).
- Read:
  - rd_en at edge N gives rd_data = word[rd_row][rd_col] and rd_valid=1 after edge N; without rd_en, rd_valid=0 and rd_data holds its value.
  - Reads return the pre-edge value, so a same-cycle write to the same address returns the old data.
  - Reads are allowed in every state; in CLEAR they return the current (partly cleared) contents.

Test Plan:
- Reset, then write tiles at (0,0),(0,2),…,(6,6) with c1..c4 = 0x0101*k, reading every cell -> each cell matches its quadrant value; frame_done=1 the cycle after the 16th accept; wr_ready=0 afterwards.
- Write tile (2,4) with 1,2,3,4, then again with wr_acc=1 and 0xFFFF,1,1,1 -> cells (2,4)=0x0000 (wrap), (2,5)=3, (3,4)=4, (3,5)=5; dup_err stays 0.
- Write tile (2,4) twice with wr_acc=0 -> dup_err=1 and the second values are stored; clear -> dup_err=0.
- Full frame then clear -> busy=1 for exactly 8 cycles, wr_ready=0 throughout; all 64 reads return 0 afterwards; frame_done=0.
- clear and wr_valid in the same cycle, then reset asserted at sweep cycle 3 -> tile not written; after reset, state is FILL, busy=0 and all words are 0.
- rd_en to (1,1) in the same cycle as accepting tile (0,0) with c4=0xABCD -> rd_data returns the old 0; a read one cycle later returns 0xABCD; wr_row=1/wr_col=1 lands at (0,0).

Source files
------------

// File: rtl/systolic_result_buffer.sv
// Result store behind the systolic array: accepts 2x2 output tiles, overwrites or
// accumulates them into a DIM x DIM word matrix, tracks completion and drains via a read port.
module systolic_result_buffer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int DIM    = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [ADDR_W-1:0] wr_col,
    input  logic              wr_acc,
    input  logic [ACC_W-1:0]  wr_c1,
    input  logic [ACC_W-1:0]  wr_c2,
    input  logic [ACC_W-1:0]  wr_c3,
    input  logic [ACC_W-1:0]  wr_c4,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_row,
    input  logic [ADDR_W-1:0] rd_col,
    output logic [ACC_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              dup_err
);

    localparam int HALF   = DIM / 2;
    localparam int NTILES = HALF * HALF;
    localparam int NWORDS = DIM * DIM;

    // Elaboration-time sanity checks on the parameter set.
    if (ACC_W < DATA_W) begin : g_acc_width_check
        $error("ACC_W must be at least DATA_W");
    end
    if ((1 << ADDR_W) != DIM || DIM < 2) begin : g_dim_check
        $error("DIM must be a power of two >= 2 and equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   sweep_reg, sweep_next;
    logic [NTILES-1:0]   tile_reg, tile_next;
    logic [NTILES-1:0]   tile_hit;
    logic                dup_reg, dup_next;
    logic [ACC_W-1:0]    rd_data_reg;
    logic                rd_valid_reg;

    logic                accept;
    logic                clearing;
    logic                frame_complete;
    logic [ADDR_W-1:0]   tile_row;
    logic [ADDR_W-1:0]   tile_col;
    logic [ACC_W-1:0]    word_arr [NWORDS];

    assign accept   = wr_valid && wr_ready;
    assign clearing = (state_reg == CLEAR);
    // Bit 0 of the origin is ignored: tiles are always 2x2 aligned.
    assign tile_row = wr_row >> 1;
    assign tile_col = wr_col >> 1;

    // One-hot decode of the accepted tile into the bitmap index space.
    for (genvar gi = 0; gi < NTILES; gi++) begin : g_tile
        assign tile_hit[gi] = accept
                              && (tile_row == ADDR_W'(gi / HALF))
                              && (tile_col == ADDR_W'(gi % HALF));
    end

    assign frame_complete = &(tile_reg | tile_hit);

    // Word storage: registers rather than RAM, since reset must zero every word in one cycle
    // and the sweep clears a whole row per cycle.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            logic [ACC_W-1:0] word_reg;
            logic [ACC_W-1:0] wr_val;
            logic             word_hit;

            assign word_hit = tile_hit[(gi / 2) * HALF + (gj / 2)];
            assign wr_val   = (gi % 2 == 0) ? ((gj % 2 == 0) ? wr_c1 : wr_c2)
                                            : ((gj % 2 == 0) ? wr_c3 : wr_c4);

            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (clearing && (sweep_reg == ADDR_W'(gi))) begin
                    word_reg <= '0;
                end else if (word_hit) begin
                    word_reg <= wr_acc ? (word_reg + wr_val) : wr_val;
                end
            end

            assign word_arr[gi * DIM + gj] = word_reg;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FILL;
            sweep_reg <= '0;
            tile_reg  <= '0;
            dup_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
            tile_reg  <= tile_next;
            dup_reg   <= dup_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        unique case (state_reg)
            FILL: begin
                if (clear) begin
                    state_next = CLEAR;
                    sweep_next = '0;
                end else if (accept && frame_complete) begin
                    state_next = DONE;
                end
            end
            CLEAR: begin
                if (clear) begin
                    sweep_next = '0;
                end else if (sweep_reg == ADDR_W'(DIM - 1)) begin
                    state_next = FILL;
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_reg + 1'b1;
                end
            end
            DONE: begin
                if (clear) begin
                    state_next = CLEAR;
                    sweep_next = '0;
                end
            end
            default: begin
                state_next = FILL;
                sweep_next = '0;
            end
        endcase
    end

    // Bitmap and duplicate-write flag; both drop on the edge that starts a sweep.
    always_comb begin
        tile_next = tile_reg | tile_hit;
        dup_next  = dup_reg;
        if (clear) begin
            tile_next = '0;
            dup_next  = 1'b0;
        end else if (accept && !wr_acc && |(tile_reg & tile_hit)) begin
            dup_next = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        wr_ready   = (state_reg == FILL) && !clear;
        busy       = (state_reg == CLEAR);
        frame_done = (state_reg == DONE);
        dup_err    = dup_reg;
    end

    // Registered read port; returns pre-edge contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_data_reg <= word_arr[{rd_row, rd_col}];
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_systolic_result_buffer.sv
// Self-checking bench for systolic_result_buffer: directed scenarios plus random traffic,
// compared every cycle against a behavioural matrix model.
module tb_systolic_result_buffer;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int DIM    = 8;
    localparam int ADDR_W = 3;
    localparam int HT     = DIM / 2;

    localparam int S_FILL  = 0;
    localparam int S_CLEAR = 1;
    localparam int S_DONE  = 2;

    logic              clk = 1'b0;
    logic              reset, wr_valid, wr_acc, clear, rd_en;
    logic [ADDR_W-1:0] wr_row, wr_col, rd_row, rd_col;
    logic [ACC_W-1:0]  wr_c1, wr_c2, wr_c3, wr_c4;
    logic              wr_ready, rd_valid, busy, frame_done, dup_err;
    logic [ACC_W-1:0]  rd_data;

    always #5 clk = ~clk;

    systolic_result_buffer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .DIM(DIM), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_acc(wr_acc),
        .wr_c1(wr_c1), .wr_c2(wr_c2), .wr_c3(wr_c3), .wr_c4(wr_c4),
        .clear(clear),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .frame_done(frame_done), .dup_err(dup_err)
    );

    int checks = 0;
    int passed = 0;

    // Behavioural model
    logic [ACC_W-1:0] m_mem [DIM][DIM];
    bit               m_tile [HT*HT];
    int               m_state;
    int               m_sweep;
    logic [ACC_W-1:0] m_rd_data;
    bit               m_rd_valid;
    bit               m_dup;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) m_mem[r][c] = '0;
        for (int t = 0; t < HT*HT; t++) m_tile[t] = 0;
        m_state = S_FILL; m_sweep = 0;
        m_rd_data = '0; m_rd_valid = 0; m_dup = 0;
    endfunction

    function automatic void model_edge();
        int r, c, t;
        bit ready, all_set;
        logic [ACC_W-1:0] vals [4];
        if (reset) begin
            model_reset();
            return;
        end
        ready = (m_state == S_FILL) && !clear;
        m_rd_valid = rd_en;
        if (rd_en) m_rd_data = m_mem[rd_row][rd_col];
        if (m_state == S_CLEAR)
            for (int j = 0; j < DIM; j++) m_mem[m_sweep][j] = '0;
        if (clear) begin
            m_state = S_CLEAR; m_sweep = 0; m_dup = 0;
            for (int i = 0; i < HT*HT; i++) m_tile[i] = 0;
        end else if (m_state == S_CLEAR) begin
            if (m_sweep == DIM - 1) m_state = S_FILL;
            m_sweep = (m_sweep + 1) % DIM;
        end else if (ready && wr_valid) begin
            r = int'(wr_row) & ~1;
            c = int'(wr_col) & ~1;
            vals[0] = wr_c1; vals[1] = wr_c2; vals[2] = wr_c3; vals[3] = wr_c4;
            for (int k = 0; k < 4; k++) begin
                if (wr_acc) m_mem[r + k/2][c + k%2] = m_mem[r + k/2][c + k%2] + vals[k];
                else        m_mem[r + k/2][c + k%2] = vals[k];
            end
            t = (r / 2) * HT + (c / 2);
            if (!wr_acc && m_tile[t]) m_dup = 1;
            m_tile[t] = 1;
            all_set = 1;
            for (int i = 0; i < HT*HT; i++) if (!m_tile[i]) all_set = 0;
            if (all_set) m_state = S_DONE;
        end
    endfunction

    // One clock: check combinational ready, advance model, then compare registered outputs.
    task automatic step();
        #1;
        chk("wr_ready", wr_ready, (m_state == S_FILL) && !clear);
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid, m_rd_valid);
        chk("rd_data", rd_data, m_rd_data);
        chk("busy", busy, m_state == S_CLEAR);
        chk("frame_done", frame_done, m_state == S_DONE);
        chk("dup_err", dup_err, m_dup);
    endtask

    task automatic idle();
        reset = 0; wr_valid = 0; wr_acc = 0; clear = 0; rd_en = 0;
        wr_row = '0; wr_col = '0; rd_row = '0; rd_col = '0;
        wr_c1 = '0; wr_c2 = '0; wr_c3 = '0; wr_c4 = '0;
    endtask

    task automatic wr_tile(input int r, input int c, input bit acc,
                           input logic [ACC_W-1:0] v1, input logic [ACC_W-1:0] v2,
                           input logic [ACC_W-1:0] v3, input logic [ACC_W-1:0] v4);
        wr_valid = 1; wr_row = ADDR_W'(r); wr_col = ADDR_W'(c); wr_acc = acc;
        wr_c1 = v1; wr_c2 = v2; wr_c3 = v3; wr_c4 = v4;
        step();
        wr_valid = 0;
    endtask

    task automatic rd(input int r, input int c);
        rd_en = 1; rd_row = ADDR_W'(r); rd_col = ADDR_W'(c);
        step();
        rd_en = 0;
    endtask

    task automatic read_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) rd(r, c);
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 4*DIM && busy; i++) step();
        chk("sweep_ends", busy, 1'b0);
    endtask

    int n;

    initial begin
        idle();
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        step();
        reset = 0;
        chk("reset_ready", wr_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);

        // Full frame of quadrant values
        for (int t = 0; t < HT*HT; t++) begin
            logic [ACC_W-1:0] v;
            v = ACC_W'((t + 1) * 16'h0101);
            wr_tile(2 * (t / HT), 2 * (t % HT), 0, v, v, v, v);
            if (t < HT*HT - 1) chk("frame_not_done", frame_done, 1'b0);
        end
        chk("frame_done_lit", frame_done, 1'b1);
        chk("ready_after_done", wr_ready, 1'b0);
        read_all();
        rd(7, 7); chk("cell77_lit", rd_data, 16'h1010);
        rd(0, 1); chk("cell01_lit", rd_data, 16'h0101);

        // Clear sweep length
        clear = 1; step(); clear = 0;
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin n++; step(); end
        chk("busy_cycles", n, 8);
        read_all();
        chk("frame_done_cleared", frame_done, 1'b0);

        // Accumulate with wrap
        wr_tile(2, 4, 0, 16'd1, 16'd2, 16'd3, 16'd4);
        wr_tile(2, 4, 1, 16'hFFFF, 16'd1, 16'd1, 16'd1);
        rd(2, 4); chk("acc_wrap", rd_data, 16'h0000);
        rd(2, 5); chk("acc_25", rd_data, 16'd3);
        rd(3, 4); chk("acc_34", rd_data, 16'd4);
        rd(3, 5); chk("acc_35", rd_data, 16'd5);
        chk("acc_no_dup", dup_err, 1'b0);

        // Duplicate overwrite
        wr_tile(2, 4, 0, 16'd9, 16'd9, 16'd9, 16'd9);
        chk("dup_set", dup_err, 1'b1);
        rd(3, 5); chk("dup_value", rd_data, 16'd9);
        clear = 1; step(); clear = 0;
        chk("dup_cleared", dup_err, 1'b0);
        wait_not_busy();

        // clear + write collision, then reset at sweep cycle 3
        for (int c = 0; c < DIM; c += 2) wr_tile(6, c, 0, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
        clear = 1; wr_valid = 1; wr_row = '0; wr_col = '0; wr_acc = 0;
        wr_c1 = 16'h1111; wr_c2 = 16'h1111; wr_c3 = 16'h1111; wr_c4 = 16'h1111;
        step();
        clear = 0; wr_valid = 0;
        step(); step();
        reset = 1; step(); reset = 0;
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_ready", wr_ready, 1'b1);
        rd(6, 6); chk("post_reset_66", rd_data, 16'h0000);
        rd(0, 0); chk("collision_00", rd_data, 16'h0000);
        read_all();

        // Same-cycle read returns old data; odd origin lands on (0,0)
        wr_valid = 1; wr_row = 3'd1; wr_col = 3'd1; wr_acc = 0;
        wr_c1 = 16'h0011; wr_c2 = 16'h0022; wr_c3 = 16'h0033; wr_c4 = 16'hABCD;
        rd_en = 1; rd_row = 3'd1; rd_col = 3'd1;
        step();
        wr_valid = 0; rd_en = 0;
        chk("raw_old", rd_data, 16'h0000);
        rd(1, 1); chk("raw_new", rd_data, 16'hABCD);
        rd(0, 0); chk("odd_origin", rd_data, 16'h0011);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(599) == 0);
            clear    = ($urandom_range(199) == 0);
            wr_valid = ($urandom_range(9) < 7);
            wr_row   = ADDR_W'($urandom_range(DIM - 1));
            wr_col   = ADDR_W'($urandom_range(DIM - 1));
            wr_acc   = $urandom_range(1);
            wr_c1    = ACC_W'($urandom); wr_c2 = ACC_W'($urandom);
            wr_c3    = ACC_W'($urandom); wr_c4 = ACC_W'($urandom);
            rd_en    = $urandom_range(1);
            rd_row   = ADDR_W'($urandom_range(DIM - 1));
            rd_col   = ADDR_W'($urandom_range(DIM - 1));
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
